// File: rtl/am_key_receiver.sv
// am_key_receiver: recovers the beep envelope from a 1-bit carrier, locks to per-bit sync beeps and decodes the key LSB-first
module am_key_receiver #(
   parameter int PERIOD_LOG2    = 26,
   parameter int KEY_W          = 64,
   parameter int HOLD_CYCLES    = 65536,
   parameter int SYNC_GAP_SLOTS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             antena_in,
   output logic [KEY_W-1:0] key_out,
   output logic             key_valid,
   output logic             sync_err,
   output logic             busy,
   output logic [6:0]       bit_cnt
);
   localparam int SLOT    = 2 ** (PERIOD_LOG2 - 3);
   localparam int GAP_MAX = SYNC_GAP_SLOTS * SLOT;
   localparam int HW      = $clog2(HOLD_CYCLES + 1);
   localparam int GW      = $clog2(GAP_MAX + 1);
   localparam logic [PERIOD_LOG2-1:0] SYNC_PT = PERIOD_LOG2'(SLOT / 2);
   localparam logic [PERIOD_LOG2-1:0] DATA_PT = PERIOD_LOG2'(2 * SLOT + SLOT / 2);

   typedef enum logic [1:0] {HUNT, ARMED, RECV, DONE} state_t;

   state_t                 state, state_n;
   logic [2:0]             sync;
   logic [HW-1:0]          hold;
   logic [GW-1:0]          gap;
   logic                   env_d;
   logic [PERIOD_LOG2-1:0] phase;
   logic [KEY_W-1:0]       shift;

   wire              rise     = sync[1] & ~sync[2];
   wire              env      = hold != '0;
   wire              env_rise = env & ~env_d;
   wire              gap_full = gap == GW'(GAP_MAX);
   wire [KEY_W-1:0]  shift_n  = {env, shift[KEY_W-1:1]};

   assign busy = (state == ARMED) || (state == RECV);

   // synchronise the carrier, stretch its rising edges into an envelope and time the silence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         hold  <= '0;
         env_d <= 1'b0;
         gap   <= '0;
      end else begin
         sync  <= {sync[1:0], antena_in};
         hold  <= rise ? HW'(HOLD_CYCLES) : (env ? hold - 1'b1 : hold);
         env_d <= env;
         gap   <= env ? '0 : (gap_full ? gap : gap + 1'b1);
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= HUNT;
      else        state <= state_n;
   end

   // next state and single-cycle status pulses
   always_comb begin
      state_n   = state;
      sync_err  = 1'b0;
      key_valid = 1'b0;
      case (state)
         HUNT:  state_n = gap_full ? ARMED : HUNT;
         ARMED: state_n = env_rise ? RECV : ARMED;
         RECV: begin
            if (phase == SYNC_PT && !env) begin
               sync_err = 1'b1;
               state_n  = HUNT;
            end else if (phase == DATA_PT && bit_cnt == 7'(KEY_W - 1)) begin
               state_n = DONE;
            end
         end
         default: begin
            key_valid = 1'b1;
            state_n   = HUNT;
         end
      endcase
   end

   // bit timing and key assembly; key_out loads on entry to DONE so it is already new while key_valid is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase   <= '0;
         shift   <= '0;
         bit_cnt <= '0;
         key_out <= '0;
      end else if (state == ARMED && env_rise) begin
         phase   <= '0;
         shift   <= '0;
         bit_cnt <= '0;
      end else if (state == RECV) begin
         phase <= phase + 1'b1;
         if (sync_err) begin
            bit_cnt <= '0;
         end else if (phase == DATA_PT) begin
            shift   <= shift_n;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 7'(KEY_W - 1)) key_out <= shift_n;
         end
      end
   end
endmodule

// File: tb/tb_am_key_receiver.sv
// tb_am_key_receiver: scoreboard bench driving beep frames into am_key_receiver
module tb_am_key_receiver;
   localparam int PL   = 9;
   localparam int KW   = 16;
   localparam int SLOT = 2 ** (PL - 3);
   localparam int PER  = 2 ** PL;

   typedef struct {
      bit          err;
      longint      cyc;
      logic [KW-1:0] key;
   } ev_t;

   logic          clk, rst_n, antena_in;
   logic [KW-1:0] key_out;
   logic          key_valid, sync_err, busy;
   logic [6:0]    bit_cnt;

   ev_t    exp_q[$];
   ev_t    e;
   int     total = 0, bad = 0;
   longint cyc = 0;

   am_key_receiver #(.PERIOD_LOG2(PL), .KEY_W(KW), .HOLD_CYCLES(16), .SYNC_GAP_SLOTS(4)) dut (
      .clk(clk), .rst_n(rst_n), .antena_in(antena_in), .key_out(key_out),
      .key_valid(key_valid), .sync_err(sync_err), .busy(busy), .bit_cnt(bit_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(string name, logic [63:0] got, logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // monitor: every pulse must match the next scheduled event in kind, cycle and key
   always @(negedge clk) begin
      if (rst_n && (key_valid || sync_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 64'({key_valid, sync_err}), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 64'({key_valid, sync_err}), e.err ? 64'd1 : 64'd2);
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            if (!e.err) chk("key_out", 64'(key_out), 64'(e.key));
         end
      end
   end

   function automatic logic beep(int i);
      return ((i >> 2) & 1) == 0;
   endfunction

   task automatic step(logic a);
      antena_in = a;
      @(posedge clk);
      #1;
   endtask

   task automatic silence(int n);
      repeat (n) step(1'b0);
   endtask

   // one frame: sync beep in slot 0, data beep in slot 2 for a 1 bit; optional dropped sync, truncation or reset abort
   task automatic send_frame(logic [KW-1:0] key, int drop, int nbits, int abort_bit, int abort_at);
      longint fs;
      fs = cyc;
      if (drop >= 0)
         exp_q.push_back('{1'b1, fs + drop * PER + 4 + SLOT / 2, '0});
      else if (nbits == KW && abort_bit < 0)
         exp_q.push_back('{1'b0, fs + (KW - 1) * PER + 4 + 2 * SLOT + SLOT / 2 + 1, key});
      for (int b = 0; b < nbits; b++) begin
         for (int i = 0; i < PER; i++) begin
            if (b == 5 && i == 0) begin
               chk("bit_cnt_mid", 64'(bit_cnt), 64'd5);
               chk("busy_mid", 64'(busy), 64'd1);
            end
            if (b == abort_bit && i == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk("abort_key_out", 64'(key_out), 64'd0);
               chk("abort_busy", 64'(busy), 64'd0);
               chk("abort_bit_cnt", 64'(bit_cnt), 64'd0);
               return;
            end
            step((i < SLOT && b != drop) ? beep(i) :
                 (i >= 2 * SLOT && i < 3 * SLOT && key[b]) ? beep(i - 2 * SLOT) : 1'b0);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      antena_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_out", 64'(key_out), 64'd0);
      chk("rst_key_valid", 64'(key_valid), 64'd0);
      chk("rst_sync_err", 64'(sync_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
      rst_n = 1'b1;
      silence(600);
      chk("armed_after_gap", 64'(busy), 64'd1);
      send_frame(16'h8001, -1, KW, -1, 0);
      silence(600);
      send_frame(16'hFFFF, -1, KW, -1, 0);
      silence(600);
      send_frame(16'h0000, -1, KW, -1, 0);
      silence(600);
      send_frame(16'hF00D, 10, 11, -1, 0);
      chk("err_bit_cnt", 64'(bit_cnt), 64'd0);
      silence(600);
      send_frame(16'hF00D, -1, KW, -1, 0);
      silence(600);
      rst_n = 1'b0;
      step(1'b0);
      rst_n = 1'b1;
      for (int i = SLOT / 2; i < SLOT; i++) step(beep(i));
      silence(200);
      chk("midbeep_no_lock", 64'(busy), 64'd0);
      silence(200);
      chk("midbeep_armed", 64'(busy), 64'd1);
      send_frame(16'h1234, -1, KW, -1, 0);
      silence(600);
      send_frame(16'hA5A5, -1, KW, 12, 300);
      repeat (3) step(1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         if (i % 1000 == 999) chk("carrier_not_armed", 64'(busy), 64'd0);
         step(beep(i));
      end
      silence(600);
      chk("stuck0_armed", 64'(busy), 64'd1);
      silence(1000);
      chk("stuck0_still_armed", 64'(busy), 64'd1);
      chk("stuck0_bit_cnt", 64'(bit_cnt), 64'd0);
      chk("events_left", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
